// File: rtl/seg7_scan_if.sv
// Digit stream in from the benchmark core, multiplexed display pins out.
interface seg7_scan_if;
  logic [3:0] digit_in;
  logic [1:0] digit_sel;
  logic       digit_valid;
  logic [6:0] seg;
  logic [2:0] an;
  logic       frame_done;

  modport master (
    output digit_in, digit_sel, digit_valid,
    input  seg, an, frame_done
  );

  modport slave (
    input  digit_in, digit_sel, digit_valid,
    output seg, an, frame_done
  );
endinterface

// File: rtl/seg7_scan_receiver.sv
// Three-digit frame receiver and multiplexed common-anode seven-segment driver.
// Digits are staged in shadow registers; the hundreds beat commits the whole
// frame at once so a partial frame is never displayed.
module seg7_scan_receiver #(
  parameter int unsigned REFRESH_DIV  = 50,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter int unsigned LZB          = 1
) (
  input  logic       clk,
  input  logic       rst,
  seg7_scan_if.slave bus
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [2:0] AN_OFF  = 3'b111;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       shadow0_q, shadow0_d;
  logic [3:0]       shadow1_q, shadow1_d;
  logic [3:0]       disp0_q, disp0_d;
  logic [3:0]       disp1_q, disp1_d;
  logic [3:0]       disp2_q, disp2_d;
  logic             frame_done_q, frame_done_d;
  logic [6:0]       seg_q, seg_d;
  logic [2:0]       an_q, an_d;

  logic [3:0]       cur_digit;
  logic [2:0]       an_sel;
  logic             suppress;

  // Active-low {g,f,e,d,c,b,a} pattern; error codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  // Next-state: scan timing, digit capture/commit and registered pin values.
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shadow0_d    = shadow0_q;
    shadow1_d    = shadow1_q;
    disp0_d      = disp0_q;
    disp1_d      = disp1_q;
    disp2_d      = disp2_q;
    frame_done_d = 1'b0;
    seg_d        = SEG_OFF;
    an_d         = AN_OFF;
    cur_digit    = disp0_q;
    an_sel       = 3'b110;
    suppress     = 1'b0;

    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (bus.digit_valid) begin
      case (bus.digit_sel)
        2'd0: shadow0_d = bus.digit_in;
        2'd1: shadow1_d = bus.digit_in;
        2'd2: begin
          disp2_d      = bus.digit_in;
          disp1_d      = shadow1_q;
          disp0_d      = shadow0_q;
          frame_done_d = 1'b1;
        end
        default: ;
      endcase
    end

    case (idx_q)
      2'd1: begin
        cur_digit = disp1_q;
        an_sel    = 3'b101;
      end
      2'd2: begin
        cur_digit = disp2_q;
        an_sel    = 3'b011;
      end
      default: begin
        cur_digit = disp0_q;
        an_sel    = 3'b110;
      end
    endcase

    // Dashes are non-zero, so they never trigger suppression of themselves or lower digits.
    suppress = (LZB != 0) &&
               (((idx_q == 2'd2) && (disp2_q == 4'd0)) ||
                ((idx_q == 2'd1) && (disp2_q == 4'd0) && (disp1_q == 4'd0)));

    if (cnt_q >= CNT_BLANK) begin
      an_d  = an_sel;
      seg_d = suppress ? SEG_OFF : decode(cur_digit);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      shadow0_q    <= 4'd0;
      shadow1_q    <= 4'd0;
      disp0_q      <= 4'd0;
      disp1_q      <= 4'd0;
      disp2_q      <= 4'd0;
      frame_done_q <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow0_q    <= shadow0_d;
      shadow1_q    <= shadow1_d;
      disp0_q      <= disp0_d;
      disp1_q      <= disp1_d;
      disp2_q      <= disp2_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_receiver.sv
// Scoreboard bench: stimulus queues expected slot contents and frame_done
// pulses; a monitor matches them as the scan presents each digit.
module tb_seg7_scan_receiver;

  localparam int RD = 8;
  localparam int BC = 2;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SB = 7'b1111111;

  typedef struct {
    int         inst;
    logic [2:0] an;
    logic [6:0] seg;
    int         tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_if m_if ();
  seg7_scan_if n_if ();

  seg7_scan_receiver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZB(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (m_if)
  );

  seg7_scan_receiver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZB(0)) u_dut_nlz (
    .clk (clk),
    .rst (rst),
    .bus (n_if)
  );

  exp_t exp_q[$];
  int   fd_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic rst_seen = 1'b0;
  logic started = 1'b0;

  logic [2:0] prev_an = 3'b111;
  logic [2:0] exp_an = 3'b110;
  int         blank_len = 0;
  int         lit_len = 0;
  logic       skip_blank = 1'b1;

  // Cycle count and a record of whether the last edge sampled reset.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
    if (rst) started <= 1'b1;
  end

  task monitor();
    exp_t       head;
    logic [2:0] cur_an;
    logic [6:0] cur_seg;
    int         want_cyc;
    forever begin
      @(negedge clk);
      if (started) begin
        if (rst_seen) begin
          checks++;
          if (m_if.an !== 3'b111 || m_if.seg !== SB || m_if.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs cyc=%0d an=%b seg=%b fd=%b want an=111 seg=1111111 fd=0",
                     cyc, m_if.an, m_if.seg, m_if.frame_done);
          end
          prev_an    = 3'b111;
          exp_an     = 3'b110;
          blank_len  = 0;
          lit_len    = 0;
          skip_blank = 1'b1;
        end else begin
          // frame_done pulses must line up with queued commits
          if (m_if.frame_done !== 1'b0) begin
            checks++;
            if (fd_q.size() == 0) begin
              errors++;
              $display("FAIL frame_done_unexpected cyc=%0d got %b want 0", cyc, m_if.frame_done);
            end else begin
              want_cyc = fd_q.pop_front();
              if (want_cyc != cyc) begin
                errors++;
                $display("FAIL frame_done_cycle got cyc %0d want cyc %0d", cyc, want_cyc);
              end
            end
          end

          // slot timing: blank runs of BC, lit runs of RD-BC, anodes rotating ones->tens->hundreds
          if (m_if.an == 3'b111) begin
            if (prev_an != 3'b111) begin
              checks++;
              if (lit_len != RD - BC) begin
                errors++;
                $display("FAIL lit_len got %0d want %0d", lit_len, RD - BC);
              end
              blank_len = 1;
            end else begin
              blank_len++;
            end
          end else begin
            if (prev_an == 3'b111) begin
              if (!skip_blank) begin
                checks++;
                if (blank_len != BC) begin
                  errors++;
                  $display("FAIL blank_len got %0d want %0d", blank_len, BC);
                end
              end
              skip_blank = 1'b0;
              checks++;
              if (m_if.an !== exp_an) begin
                errors++;
                $display("FAIL an_order got %b want %b", m_if.an, exp_an);
              end
              exp_an  = {exp_an[1:0], exp_an[2]};
              lit_len = 1;
            end else begin
              lit_len++;
            end
          end
          prev_an = m_if.an;

          // display scoreboard
          if (exp_q.size() > 0) begin
            head    = exp_q[0];
            cur_an  = (head.inst == 0) ? m_if.an : n_if.an;
            cur_seg = (head.inst == 0) ? m_if.seg : n_if.seg;
            if (cur_an == head.an) begin
              void'(exp_q.pop_front());
              checks++;
              if (cur_seg !== head.seg) begin
                errors++;
                $display("FAIL slot tag=%0d inst=%0d an=%b seg got %b want %b",
                         head.tag, head.inst, head.an, cur_seg, head.seg);
              end
            end
          end
        end
      end
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [3:0] d);
    m_if.digit_valid = v;
    m_if.digit_sel   = s;
    m_if.digit_in    = d;
    n_if.digit_valid = v;
    n_if.digit_sel   = s;
    n_if.digit_in    = d;
  endtask

  // One valid beat; the commit beat queues a frame_done one cycle later.
  task automatic send(input logic [1:0] s, input logic [3:0] d);
    drive(1'b1, s, d);
    if (s == 2'd2) fd_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    drive(1'b0, 2'd0, 4'd0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input int inst, input logic [2:0] an, input logic [6:0] seg, input int tag);
    exp_t e;
    e.inst = inst;
    e.an   = an;
    e.seg  = seg;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic push3(input int inst, input logic [6:0] o, input logic [6:0] t,
                       input logic [6:0] h, input int tag);
    push1(inst, 3'b110, o, tag);
    push1(inst, 3'b101, t, tag);
    push1(inst, 3'b011, h, tag);
  endtask

  task automatic drain(input int tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 20 * RD) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain tag=%0d pending got %0d want 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    drive(1'b0, 2'd0, 4'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // idle after reset: ones shows 0, upper digits blanked (LZB) or 0 (no LZB)
    push3(0, S0, SB, SB, 1);
    push3(1, S0, S0, S0, 2);
    drain(1);
    repeat (3 * RD) settle();

    // frame 321 back-to-back
    send(2'd0, 4'd3);
    send(2'd1, 4'd2);
    send(2'd2, 4'd1);
    settle();
    push3(0, S3, S2, S1, 3);
    drain(3);

    // partial frame is not shown
    send(2'd0, 4'd9);
    send(2'd1, 4'd9);
    settle();
    push3(0, S3, S2, S1, 4);
    push3(0, S3, S2, S1, 5);
    drain(4);
    send(2'd2, 4'd0);
    settle();
    push3(0, S9, S9, SB, 6);
    drain(6);

    // 005: LZB blanks both upper digits, no-LZB shows zeros
    send(2'd0, 4'd5);
    send(2'd1, 4'd0);
    send(2'd2, 4'd0);
    settle();
    push3(0, S5, SB, SB, 7);
    push3(1, S5, S0, S0, 8);
    drain(7);

    // error code on ones shows a dash
    send(2'd0, 4'd12);
    send(2'd1, 4'd0);
    send(2'd2, 4'd0);
    settle();
    push3(0, SD, SB, SB, 9);
    drain(9);

    // reserved select changes nothing and does not pulse frame_done
    send(2'd3, 4'd7);
    settle();
    push3(0, SD, SB, SB, 10);
    drain(10);

    // reset mid-frame clears shadows; later commit brings in zeros
    send(2'd0, 4'd4);
    send(2'd1, 4'd4);
    rst = 1'b1;
    settle();
    rst = 1'b0;
    send(2'd2, 4'd1);
    settle();
    push3(0, S0, S0, S1, 11);
    push3(1, S0, S0, S1, 12);
    drain(11);

    repeat (2 * RD) settle();
    checks++;
    if (fd_q.size() != 0) begin
      errors++;
      $display("FAIL frame_done_missing pending got %0d want 0", fd_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_receiver.md
Name: seg7_scan_receiver

Overview:
- Receives the serial digit stream produced by the reaction-time benchmark: a 4-bit BCD digit plus a 2-bit digit select.
- Assembles the digits into a three-digit frame and commits each completed frame atomically to a display register.
- Drives a three-digit multiplexed common-anode seven-segment display, with anti-ghosting blanking and leading-zero suppression.
- Sits between the benchmark core and the board pins.

Parameters:
- REFRESH_DIV, 50: clock cycles per digit slot. At 50 kHz this is 1 ms per digit.
- BLANK_CYCLES, 2: cycles at the start of each slot with all anodes off. Must be less than REFRESH_DIV.
- LZB, 1: 1 enables leading-zero blanking; 0 shows all digits.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- digit_in, input, 4: digit value. 0–9 is valid; 10–15 is an error code.
- digit_sel, input, 2: 0 = ones, 1 = tens, 2 = hundreds, 3 = reserved.
- digit_valid, input, 1: qualifies digit_in and digit_sel in the same cycle.
- seg, output, 7: segments {g,f,e,d,c,b,a}, active-low, registered.
- an, output, 3: anodes, active-low. an[0] = ones, an[1] = tens, an[2] = hundreds. Registered.
- frame_done, output, 1: one-cycle pulse after a frame commit.

Behaviour:
- Reset (rst=1 at a posedge; rst wins over all other inputs):
  - shadow0, shadow1, disp0, disp1, disp2 all = 0.
  - Slot counter = 0, scan index = 0.
  - seg = 7'b1111111, an = 3'b111, frame_done = 0.
- Capture, on a posedge with digit_valid=1:
  - sel=0: shadow0 <= digit_in.
  - sel=1: shadow1 <= digit_in.
  - sel=2: disp2 <= digit_in, disp1 <= shadow1, disp0 <= shadow0 (the commit). frame_done is 1 in the following cycle only.
  - sel=3: ignored; no state change.
  - digit_valid=0: no capture.
- Display registers change only on a commit. A partially received frame is never shown.
- Frame ordering:
  - Digits may arrive in any order and at any rate, including back-to-back cycles.
  - A repeated sel overwrites the earlier value.
  - A commit with a stale shadow value uses that stale value.
- Scan:
  - Counter runs 0..REFRESH_DIV-1.
  - On wrap, the scan index advances 0→1→2→0.
  - The scan runs continuously from reset, independent of capture.
- Output registers, updated every cycle from the current counter, index and disp registers (latency 1 cycle):
  - If counter < BLANK_CYCLES: an = 3'b111, seg = 7'b1111111.
  - Otherwise: an = one-cold at the index, seg = decode(disp[index]), or blank if the digit is suppressed.
- Decode (active-low):
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
  - 10–15 = 0111111 (dash, segment g only)
- Leading-zero blanking (LZB=1):
  - Hundreds is suppressed when disp2 = 0.
  - Tens is suppressed when disp2 = 0 and disp1 = 0.
  - Ones is never suppressed.
  - For a suppressed digit, the anode is still driven per the scan and seg = 1111111.
  - A dash (10–15) is never suppressed and counts as non-zero.
- Commit during an active slot: the new value appears on seg in the next cycle, without waiting for a slot boundary.
- Reset mid-frame: shadows are cleared. A later sel=2 commits zeros for any digits not re-sent.

Test Plan:
- Reset, then 3·REFRESH_DIV idle cycles (REFRESH_DIV=8, BLANK_CYCLES=2) → frame_done never pulses. Every slot shows an=111 for 2 cycles and seg=1111111 throughout: ones is 0 → 1000000 when an=110; tens and hundreds are blanked.
- Send (sel0,3), (sel1,2), (sel2,1) on consecutive valid cycles → frame_done=1 for exactly the cycle after the sel2 beat. Ones slot: an=110, seg=0110000. Tens slot: an=101, seg=0100100. Hundreds slot: an=011, seg=1111001.
- After the committed frame 321, send only (sel0,9) and (sel1,9) → display still shows 321 over 3 full slots. Then send (sel2,0) → display shows 99 with hundreds blank.
- Commit (sel0,5), (sel1,0), (sel2,0) → only the ones digit is lit, seg=0010010. Repeat with LZB=0 → tens and hundreds show 1000000.
- Commit ones=12 → ones slot seg=0111111. A valid beat with sel=3 and digit_in=7 → no register change and no frame_done.
- Send (sel0,4) and (sel1,4), assert rst for 1 cycle, then send (sel2,1) → display shows 100 (ones=0, tens=0, hundreds=1). Throughout reset, an=111 and seg=1111111.
